// File: rtl/xlr8_gpio_bank_if.sv
// AVR I/O bus bundle seen by xlr8_gpio_bank: I/O and extended-space decode inputs plus the
// read-data return path that is OR-muxed into the core read bus.
interface xlr8_gpio_bank_if;
    logic [5:0] adr;
    logic [7:0] dbus_in;
    logic       iore;
    logic       iowe;
    logic [7:0] ramadr;
    logic       ramre;
    logic       ramwe;
    logic       dm_sel;
    logic [7:0] dbus_out;
    logic       io_out_en;

    modport master (
        output adr, dbus_in, iore, iowe, ramadr, ramre, ramwe, dm_sel,
        input  dbus_out, io_out_en
    );

    modport slave (
        input  adr, dbus_in, iore, iowe, ramadr, ramre, ramwe, dm_sel,
        output dbus_out, io_out_en
    );
endinterface

// File: rtl/xlr8_gpio_bank.sv
// Parametrised GPIOR / read-only config register bank with a CLKSPD register whose writable
// bit is protected by a timed CCP key unlock.
module xlr8_gpio_bank #(
    parameter logic [31:0] DESIGN_CONFIG = 32'h9,
    parameter int          NUM_GPIOR     = 3,
    parameter logic [7:0]  GPIOR_BASE    = 8'h3E,
    parameter int          NUM_ROREG     = 4,
    parameter logic [7:0]  ROREG_BASE    = 8'h00,
    parameter logic [63:0] ROREG_VALS    = 64'h0,
    parameter logic [7:0]  CLKSPD_ADDR   = 8'h49,
    parameter logic [7:0]  CCP_ADDR      = 8'h54,
    parameter logic [7:0]  CCP_KEY       = 8'hD8,
    parameter int          CCP_WINDOW    = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   i_clken,
    xlr8_gpio_bank_if.slave        bus,
    output logic [8*((NUM_GPIOR > 0) ? NUM_GPIOR : 1)-1:0] o_gpior_q,
    output logic                   o_intosc_div1024_en
);

    localparam int         NG    = (NUM_GPIOR > 0) ? NUM_GPIOR : 1;
    localparam int         NR    = (NUM_ROREG > 0) ? NUM_ROREG : 1;
    localparam bit         RO_EN = (ROREG_BASE != 8'h00) && (NUM_ROREG > 0);
    localparam logic [3:0] WIN   = 4'(CCP_WINDOW);
    localparam logic [7:0] SPEED = (DESIGN_CONFIG[2:1] == 2'b01) ? 8'h22 :
                                   (DESIGN_CONFIG[2:1] == 2'b10) ? 8'h44 : 8'h10;

    typedef enum logic {IDLE, OPEN} ccpState_t;

    // Addresses below 0x60 live in I/O space (adr = A - 0x20); the rest need dm_sel + ramadr.
    function automatic logic addrHit(input logic [7:0] a, input logic [5:0] adr,
                                     input logic [7:0] ramadr, input logic dmSel);
        logic [7:0] ioA;
        ioA = a - 8'h20;
        if (a < 8'h60)
            return {2'b00, adr} == ioA;
        else
            return dmSel && (ramadr == a);
    endfunction

    function automatic logic strobeOf(input logic [7:0] a, input logic ioS, input logic ramS);
        return (a < 8'h60) ? ioS : ramS;
    endfunction

    logic [7:0]    r_gpior [NG];
    ccpState_t     r_state;
    logic [3:0]    r_cnt;
    logic          r_intoscEn;

    logic [NG-1:0] w_gpiorSel;
    logic [NG-1:0] w_gpiorWr;
    logic [NG-1:0] w_gpiorRd;
    logic [NR-1:0] w_roSel;
    logic [NR-1:0] w_roRd;
    logic          w_clkspdSel;
    logic          w_clkspdWr;
    logic          w_clkspdRd;
    logic          w_ccpSel;
    logic          w_ccpWr;
    logic          w_ccpRd;
    logic          w_ccpKey;
    logic [7:0]    w_clkspdVal;
    logic [7:0]    w_ccpVal;
    logic [7:0]    w_dbusOut;
    logic          w_outEn;

    genvar g;
    generate
        if (NUM_GPIOR > 0) begin : gen_gpior
            for (g = 0; g < NUM_GPIOR; g++) begin : gen_reg
                localparam logic [7:0] A = GPIOR_BASE + 8'(g);

                assign w_gpiorSel[g] = addrHit(A, bus.adr, bus.ramadr, bus.dm_sel);
                assign w_gpiorWr[g]  = w_gpiorSel[g] && strobeOf(A, bus.iowe, bus.ramwe);
                assign w_gpiorRd[g]  = w_gpiorSel[g] && strobeOf(A, bus.iore, bus.ramre);
                assign o_gpior_q[8*g +: 8] = r_gpior[g];

                always_ff @(posedge clk or negedge rstn) begin
                    if (!rstn)
                        r_gpior[g] <= 8'h00;
                    else if (i_clken && w_gpiorWr[g])
                        r_gpior[g] <= bus.dbus_in;
                end
            end
        end else begin : gen_no_gpior
            assign w_gpiorSel = '0;
            assign w_gpiorWr  = '0;
            assign w_gpiorRd  = '0;
            assign o_gpior_q  = '0;
            assign r_gpior[0] = 8'h00;
        end
    endgenerate

    genvar r;
    generate
        for (r = 0; r < NR; r++) begin : gen_roreg
            if (RO_EN) begin : gen_hit
                localparam logic [7:0] A = ROREG_BASE + 8'(r);
                assign w_roSel[r] = addrHit(A, bus.adr, bus.ramadr, bus.dm_sel);
                assign w_roRd[r]  = w_roSel[r] && strobeOf(A, bus.iore, bus.ramre);
            end else begin : gen_off
                assign w_roSel[r] = 1'b0;
                assign w_roRd[r]  = 1'b0;
            end
        end
    endgenerate

    assign w_clkspdSel = addrHit(CLKSPD_ADDR, bus.adr, bus.ramadr, bus.dm_sel);
    assign w_clkspdWr  = w_clkspdSel && strobeOf(CLKSPD_ADDR, bus.iowe, bus.ramwe);
    assign w_clkspdRd  = w_clkspdSel && strobeOf(CLKSPD_ADDR, bus.iore, bus.ramre);
    assign w_ccpSel    = addrHit(CCP_ADDR, bus.adr, bus.ramadr, bus.dm_sel);
    assign w_ccpWr     = w_ccpSel && strobeOf(CCP_ADDR, bus.iowe, bus.ramwe);
    assign w_ccpRd     = w_ccpSel && strobeOf(CCP_ADDR, bus.iore, bus.ramre);
    assign w_ccpKey    = (bus.dbus_in == CCP_KEY);

    assign w_clkspdVal = {SPEED[7:1], r_intoscEn};
    assign w_ccpVal    = {7'b0, (r_state == OPEN)};

    always_comb begin
        w_dbusOut = 8'h00;
        w_outEn   = 1'b0;
        for (int i = 0; i < NG; i++) begin
            w_dbusOut = w_dbusOut | ({8{w_gpiorSel[i]}} & r_gpior[i]);
            w_outEn   = w_outEn | w_gpiorRd[i];
        end
        for (int i = 0; i < NR; i++) begin
            w_dbusOut = w_dbusOut | ({8{w_roSel[i]}} & ROREG_VALS[8*i +: 8]);
            w_outEn   = w_outEn | w_roRd[i];
        end
        w_dbusOut = w_dbusOut | ({8{w_clkspdSel}} & w_clkspdVal) | ({8{w_ccpSel}} & w_ccpVal);
        w_outEn   = w_outEn | w_clkspdRd | w_ccpRd;
    end

    assign bus.dbus_out        = w_dbusOut;
    assign bus.io_out_en       = w_outEn;
    assign o_intosc_div1024_en = r_intoscEn;

    // CCP write takes priority over a same-cycle CLKSPD write; an accepted CLKSPD write relocks.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_cnt      <= 4'd0;
            r_intoscEn <= 1'b0;
        end else if (!i_clken) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_ccpWr && w_ccpKey) begin
                        r_state <= OPEN;
                        r_cnt   <= WIN;
                    end
                end
                OPEN: begin
                    if (w_ccpWr) begin
                        if (w_ccpKey) begin
                            r_cnt <= WIN;
                        end else begin
                            r_state <= IDLE;
                            r_cnt   <= 4'd0;
                        end
                    end else if (w_clkspdWr) begin
                        r_intoscEn <= bus.dbus_in[0];
                        r_state    <= IDLE;
                        r_cnt      <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                        if (r_cnt <= 4'd1)
                            r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xlr8_gpio_bank.sv
// Directed self-checking bench for xlr8_gpio_bank: GPIOR/ROREG access, CCP unlock window,
// clken gating and asynchronous reset.
module tb_xlr8_gpio_bank;

    localparam logic [7:0] GPIOR0  = 8'h3E;
    localparam logic [7:0] GPIOR2  = 8'h40;
    localparam logic [7:0] RO0     = 8'h70;
    localparam logic [7:0] RO1     = 8'h71;
    localparam logic [7:0] CLKSPD  = 8'h49;
    localparam logic [7:0] CCP     = 8'h54;
    localparam logic [7:0] KEY     = 8'hD8;

    typedef enum {opIdle, opIoWr, opIoRd, opExtWr, opExtRd} busOp_t;

    logic        clk;
    logic        rstn;
    logic        clken;
    logic [23:0] gpiorQ;
    logic        intoscEn;
    int          checks;
    int          errors;

    xlr8_gpio_bank_if bus ();

    xlr8_gpio_bank #(
        .DESIGN_CONFIG (32'h9),
        .NUM_GPIOR     (3),
        .GPIOR_BASE    (8'h3E),
        .NUM_ROREG     (4),
        .ROREG_BASE    (8'h70),
        .ROREG_VALS    (64'h0000_0000_5678_3412),
        .CLKSPD_ADDR   (8'h49),
        .CCP_ADDR      (8'h54),
        .CCP_KEY       (8'hD8),
        .CCP_WINDOW    (4)
    ) dut (
        .clk                 (clk),
        .rstn                (rstn),
        .i_clken             (clken),
        .bus                 (bus),
        .o_gpior_q           (gpiorQ),
        .o_intosc_div1024_en (intoscEn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Drives one bus operation and parks at the falling edge so combinational reads can be sampled.
    task automatic applyStimulus(input busOp_t op, input logic [7:0] addr, input logic [7:0] data);
        logic [7:0] ioA;
        ioA = addr - 8'h20;
        case (op)
            opIoWr:  begin bus.adr = ioA[5:0]; bus.dbus_in = data; bus.iowe = 1'b1; end
            opIoRd:  begin bus.adr = ioA[5:0]; bus.iore = 1'b1; end
            opExtWr: begin bus.ramadr = addr; bus.dm_sel = 1'b1; bus.dbus_in = data; bus.ramwe = 1'b1; end
            opExtRd: begin bus.ramadr = addr; bus.dm_sel = 1'b1; bus.ramre = 1'b1; end
            default: ;
        endcase
        @(negedge clk);
    endtask

    task automatic finishCycle();
        @(posedge clk);
        #1;
        bus.adr = 6'h00; bus.dbus_in = 8'h00; bus.iore = 1'b0; bus.iowe = 1'b0;
        bus.ramadr = 8'h00; bus.ramre = 1'b0; bus.ramwe = 1'b0; bus.dm_sel = 1'b0;
    endtask

    task automatic busWrite(input busOp_t op, input logic [7:0] addr, input logic [7:0] data);
        applyStimulus(op, addr, data);
        finishCycle();
    endtask

    task automatic busRead(input busOp_t op, input logic [7:0] addr, input string tag,
                           input logic [7:0] exp);
        applyStimulus(op, addr, 8'h00);
        checkOutput(tag, {24'h0, bus.dbus_out}, {24'h0, exp});
        checkOutput({tag, "_oe"}, {31'h0, bus.io_out_en}, 32'h1);
        finishCycle();
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(opIdle, 8'h00, 8'h00);
            finishCycle();
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not end, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        rstn   = 1'b0;
        clken  = 1'b1;
        bus.adr = 6'h00; bus.dbus_in = 8'h00; bus.iore = 1'b0; bus.iowe = 1'b0;
        bus.ramadr = 8'h00; bus.ramre = 1'b0; bus.ramwe = 1'b0; bus.dm_sel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_gpior", {8'h0, gpiorQ}, 32'h0);
        checkOutput("rst_en", {31'h0, intoscEn}, 32'h0);
        checkOutput("rst_oe", {31'h0, bus.io_out_en}, 32'h0);
        checkOutput("rst_dbus", {24'h0, bus.dbus_out}, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // GPIOR write/read over I/O space
        busWrite(opIoWr, GPIOR2, 8'hA5);
        checkOutput("gpior2_q", {8'h0, gpiorQ}, 32'h00A5_0000);
        busRead(opIoRd, GPIOR2, "gpior2_rd", 8'hA5);
        busWrite(opIoWr, GPIOR0, 8'h3C);
        checkOutput("gpior0_q", {8'h0, gpiorQ}, 32'h00A5_003C);
        busRead(opIoRd, GPIOR0, "gpior0_rd", 8'h3C);

        applyStimulus(opIoRd, 8'h21, 8'h00);
        checkOutput("nosel_dbus", {24'h0, bus.dbus_out}, 32'h0);
        checkOutput("nosel_oe", {31'h0, bus.io_out_en}, 32'h0);
        finishCycle();

        // Read-only registers in extended space
        busRead(opExtRd, RO1, "ro1_rd", 8'h34);
        busWrite(opExtWr, RO1, 8'hFF);
        busRead(opExtRd, RO1, "ro1_after_wr", 8'h34);
        busRead(opExtRd, RO0, "ro0_rd", 8'h12);

        // CLKSPD without unlock
        busWrite(opIoWr, CLKSPD, 8'h01);
        checkOutput("locked_en", {31'h0, intoscEn}, 32'h0);
        busRead(opIoRd, CLKSPD, "clkspd_rd0", 8'h10);

        // Window expiry: open for CCP_WINDOW edges after the key
        busWrite(opIoWr, CCP, KEY);
        busRead(opIoRd, CCP, "ccp_open", 8'h01);
        idleCycles(3);
        busRead(opIoRd, CCP, "ccp_expired", 8'h00);
        busWrite(opIoWr, CLKSPD, 8'h01);
        checkOutput("expired_en", {31'h0, intoscEn}, 32'h0);

        // Non-key CCP write aborts the window
        busWrite(opIoWr, CCP, KEY);
        busWrite(opIoWr, CCP, 8'h00);
        busWrite(opIoWr, CLKSPD, 8'h01);
        checkOutput("abort_en", {31'h0, intoscEn}, 32'h0);

        // Successful unlock three cycles after key, then single-use relock
        busWrite(opIoWr, CCP, KEY);
        idleCycles(2);
        busWrite(opIoWr, CLKSPD, 8'h01);
        checkOutput("unlock_en", {31'h0, intoscEn}, 32'h1);
        busRead(opIoRd, CLKSPD, "clkspd_rd1", 8'h11);
        busRead(opIoRd, CCP, "ccp_relocked", 8'h00);
        busWrite(opIoWr, CLKSPD, 8'h00);
        checkOutput("relock_en", {31'h0, intoscEn}, 32'h1);

        // Key rewrite reloads the window
        busWrite(opIoWr, CCP, KEY);
        idleCycles(3);
        busWrite(opIoWr, CCP, KEY);
        idleCycles(3);
        busWrite(opIoWr, CLKSPD, 8'h00);
        checkOutput("reload_en", {31'h0, intoscEn}, 32'h0);

        // clken low blocks writes, keeps reads, and closes the window
        clken = 1'b0;
        busWrite(opIoWr, GPIOR0, 8'hFF);
        checkOutput("clken_gpior", {8'h0, gpiorQ}, 32'h00A5_003C);
        busRead(opIoRd, GPIOR2, "clken_rd", 8'hA5);
        busWrite(opIoWr, CCP, KEY);
        clken = 1'b1;
        busRead(opIoRd, CCP, "clken_key", 8'h00);
        busWrite(opIoWr, CCP, KEY);
        clken = 1'b0;
        idleCycles(1);
        clken = 1'b1;
        busWrite(opIoWr, CLKSPD, 8'h01);
        checkOutput("clken_close_en", {31'h0, intoscEn}, 32'h0);

        // Reset during an open window
        busWrite(opIoWr, CCP, KEY);
        idleCycles(1);
        busWrite(opIoWr, CLKSPD, 8'h01);
        checkOutput("pre_rst_en", {31'h0, intoscEn}, 32'h1);
        busWrite(opIoWr, CCP, KEY);
        rstn = 1'b0;
        #2;
        checkOutput("mid_rst_gpior", {8'h0, gpiorQ}, 32'h0);
        checkOutput("mid_rst_en", {31'h0, intoscEn}, 32'h0);
        applyStimulus(opIoRd, CCP, 8'h00);
        checkOutput("mid_rst_ccp", {24'h0, bus.dbus_out}, 32'h0);
        finishCycle();
        rstn = 1'b1;
        busRead(opIoRd, CCP, "post_rst_ccp", 8'h00);
        busWrite(opIoWr, CLKSPD, 8'h01);
        checkOutput("post_rst_en", {31'h0, intoscEn}, 32'h0);
        busRead(opIoRd, CLKSPD, "post_rst_clkspd", 8'h10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
